random_draw: RTL
================

Name: random_draw

Overview:
- Consumer end of the free-running 3-bit random symbol source.
- Samples the source on request and deals symbols 0..N_SYMBOLS-1 without replacement, like a shuffled deck.
- Presents each drawn symbol on a valid/ack handshake to the terminal logic.
- Tracks which symbols have been dealt; a shuffle command restores the full deck.

Parameters:
- N_SYMBOLS, 7, number of distinct symbols in the deck (2..8).
- SYM_W, 3, symbol width in bits; must satisfy 2^SYM_W >= N_SYMBOLS.
- TIMEOUT, 15, SEARCH cycles before forced pick (used only with DRAW_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- rnd_in  input  SYM_W  random symbol stream, may change every cycle
- req  input  1  draw request, sampled in IDLE only
- ack  input  1  consumer accepts val_out, sampled in HOLD only
- shuffle  input  1  refill deck, sampled in IDLE only
- val_out  output  SYM_W  drawn symbol, registered
- val_valid  output  1  val_out holds a new drawn symbol, registered
- busy  output  1  high when state != IDLE
- deck_empty  output  1  high when remaining == 0
- remaining  output  $clog2(N_SYMBOLS+1)  symbols not yet dealt
- timeout_flag  output  1  only with DRAW_TIMEOUT_EN; see Optional Feature

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named rst.
- State: used_mask[N_SYMBOLS-1:0], where bit i is set once symbol i is dealt.
- FSM states: IDLE, SEARCH, HOLD.
- Reset (rst=1 at a rising edge, in any state, including mid-SEARCH or mid-HOLD):
  - state=IDLE, used_mask=0, remaining=N_SYMBOLS.
  - val_out=0, val_valid=0, busy=0, deck_empty=0, timeout_flag=0.
- IDLE:
  - shuffle=1: used_mask<=0, remaining<=N_SYMBOLS.
  - req=1 and deck not empty: go to SEARCH.
  - req=1 and shuffle=1 in the same cycle: both take effect; SEARCH starts with a full deck.
  - req=1 while deck_empty=1 and shuffle=0: ignored; stay in IDLE with no output change.
- SEARCH, evaluated every cycle on the current rnd_in:
  - A match is rnd_in < N_SYMBOLS and used_mask[rnd_in]==0.
  - On a match, at that edge: val_out<=rnd_in, used_mask[rnd_in]<=1, remaining<=remaining-1, val_valid<=1, go to HOLD.
  - Out-of-range values (rnd_in >= N_SYMBOLS) are always rejected.
  - Already-dealt values are rejected; stay in SEARCH.
  - req and shuffle are ignored.
- Latency: req sampled at edge E0 gives SEARCH. A match at edge E1 gives val_valid=1 after E1, so the minimum is 2 edges.
  - With an incrementing mod-N source, the worst case is N_SYMBOLS+1 edges.
- HOLD:
  - val_out and val_valid are held stable.
  - ack=1: val_valid<=0, go to IDLE.
  - req and shuffle are ignored.
  - ack is ignored outside HOLD.
- remaining never underflows.
- deck_empty is asserted in the same cycle remaining becomes 0, i.e. the cycle val_valid rises for the last symbol.
- busy is registered with the state: it rises the cycle after req is accepted and falls the cycle after ack.

Optional Feature:
- Macro: DRAW_TIMEOUT_EN.
- Defined:
  - A search counter resets on SEARCH entry and increments each SEARCH cycle without a match.
  - When the counter reaches TIMEOUT with no match, the lowest-index unused symbol is dealt exactly as in a normal match, and timeout_flag<=1.
  - timeout_flag stays high with val_valid and clears on ack.
  - A genuine match on the TIMEOUT cycle takes priority, and timeout_flag stays 0.
- Not defined: no counter and no timeout_flag port; SEARCH waits indefinitely for a matching rnd_in.

Test Plan:
- Reset with rnd_in cycling 0..6 (incrementing mod 7) -> remaining=7, deck_empty=0, val_valid=0, busy=0.
- req for 1 cycle with rnd_in=3 on the next edge -> val_out=3, val_valid=1, remaining=6; held 5 cycles without ack -> stable; ack -> val_valid=0 next cycle, busy=0.
- Seven req/ack draws on the cycling stream -> 7 distinct values 0..6, no repeats; deck_empty=1 after the 7th; an 8th req -> ignored, busy stays 0.
- rnd_in held at 7 then 3 already dealt, then 5 -> stays in SEARCH through the 7 and the 3; deals 5 when it arrives.
- shuffle and req in the same IDLE cycle with deck empty -> remaining=7, then draw completes with remaining=6; rst asserted mid-SEARCH -> IDLE, used_mask=0, remaining=7.
- DRAW_TIMEOUT_EN, TIMEOUT=15, rnd_in stuck at dealt symbol 0 with symbols 0 and 1 dealt -> after 15 SEARCH cycles val_out=2, timeout_flag=1; ack -> timeout_flag=0.

Source files
------------

// File: rtl/random_draw.sv
// Deals symbols 0..N_SYMBOLS-1 without replacement from a free-running random source.
// Define DRAW_TIMEOUT_EN to force a pick of the lowest unused symbol after TIMEOUT fruitless SEARCH cycles.
module random_draw #(
    parameter int N_SYMBOLS = 7,
    parameter int SYM_W     = 3,
    parameter int TIMEOUT   = 15
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [SYM_W-1:0]                   rnd_in,
    input  logic                               req,
    input  logic                               ack,
    input  logic                               shuffle,
    output logic [SYM_W-1:0]                   val_out,
    output logic                               val_valid,
    output logic                               busy,
    output logic                               deck_empty,
    output logic [$clog2(N_SYMBOLS+1)-1:0]     remaining
`ifdef DRAW_TIMEOUT_EN
    ,
    output logic                               timeout_flag
`endif
);

    localparam int REM_W = $clog2(N_SYMBOLS+1);
    localparam int DEPTH = 1 << SYM_W;

    typedef enum logic [1:0] {IDLE, SEARCH, HOLD} state_t;

    state_t               state;
    logic [N_SYMBOLS-1:0] used_mask;
    logic [DEPTH-1:0]     free_vec;
    logic                 hit;
    logic                 force_pick;
    logic [SYM_W-1:0]     pick_sym;

`ifdef DRAW_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT+1);
    logic [CNT_W-1:0] srch_cnt;

    function automatic logic [SYM_W-1:0] lowest_free(input logic [N_SYMBOLS-1:0] used);
        lowest_free = '0;
        for (int i = N_SYMBOLS-1; i >= 0; i--)
            if (!used[i]) lowest_free = SYM_W'(i);
    endfunction
`endif

    // Out-of-range codes land in the zero padding above N_SYMBOLS, so they never hit.
    always_comb begin
        free_vec                = '0;
        free_vec[N_SYMBOLS-1:0] = ~used_mask;
        hit                     = free_vec[rnd_in];
        force_pick              = 1'b0;
        pick_sym                = rnd_in;
`ifdef DRAW_TIMEOUT_EN
        force_pick = !hit && (srch_cnt == CNT_W'(TIMEOUT-1));
        if (!hit) pick_sym = lowest_free(used_mask);
`endif
    end

    assign busy       = (state != IDLE);
    assign deck_empty = (remaining == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            used_mask <= '0;
            remaining <= REM_W'(N_SYMBOLS);
            val_out   <= '0;
            val_valid <= 1'b0;
`ifdef DRAW_TIMEOUT_EN
            srch_cnt     <= '0;
            timeout_flag <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (shuffle) begin
                        used_mask <= '0;
                        remaining <= REM_W'(N_SYMBOLS);
                    end
                    // A simultaneous shuffle refills the deck, so the request is honoured even when empty.
                    if (req && (shuffle || remaining != '0)) begin
                        state <= SEARCH;
`ifdef DRAW_TIMEOUT_EN
                        srch_cnt <= '0;
`endif
                    end
                end
                SEARCH: begin
                    if (hit || force_pick) begin
                        val_out             <= pick_sym;
                        used_mask[pick_sym] <= 1'b1;
                        remaining           <= remaining - REM_W'(1);
                        val_valid           <= 1'b1;
                        state               <= HOLD;
`ifdef DRAW_TIMEOUT_EN
                        timeout_flag <= force_pick;
`endif
                    end else begin
`ifdef DRAW_TIMEOUT_EN
                        srch_cnt <= srch_cnt + CNT_W'(1);
`endif
                    end
                end
                HOLD: begin
                    if (ack) begin
                        val_valid <= 1'b0;
                        state     <= IDLE;
`ifdef DRAW_TIMEOUT_EN
                        timeout_flag <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
